// File: rtl/seg7_pkg.sv
// seg7_pkg: active-high 7-segment glyph constants (bit0=a..bit6=g), blank code and polarity helper
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_BLANK_AH = 7'h00;
  function automatic logic [6:0] apply_pol(input logic [6:0] glyph, input bit active_low);
    return active_low ? ~glyph : glyph;
  endfunction
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble (hex) to active-high segment pattern (seg)
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK_AH;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/displays_controller.sv
// displays_controller: registered 4-digit hex 7-segment driver; clk/rst(async high), num[15:0] in, seg0..seg3[6:0] out
module displays_controller
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3
);
  localparam logic [6:0] BLANK = apply_pol(SEG_BLANK_AH, SEG_ACTIVE_LOW);
  logic [3:0][6:0] glyph;
  logic [3:0]      blank;
  logic [27:0]     seg_d, seg_q;
  genvar g;
  for (g = 0; g < 4; g++) begin : g_dec
    hex_to_seg7 u_dec (.hex(num[4*g +: 4]), .seg(glyph[g]));
  end
  always_comb begin
    blank = BLANK_LEADING ? {num[15:12] == 4'h0, num[15:8] == 8'h00, num[15:4] == 12'h000, 1'b0} : 4'b0;
    seg_d = '0;
    for (int k = 0; k < 4; k++)
      seg_d[7*k +: 7] = apply_pol(blank[k] ? SEG_BLANK_AH : glyph[k], SEG_ACTIVE_LOW);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) seg_q <= {4{BLANK}};
    else     seg_q <= seg_d;
  assign {seg3, seg2, seg1, seg0} = seg_q;
endmodule

// File: tb/tb_displays_controller.sv
// tb_displays_controller: directed self-checking bench for three parameterisations of displays_controller
module tb_displays_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] num = 16'h0000;
  logic [6:0]  a0, a1, a2, a3;
  logic [6:0]  b0, b1, b2, b3;
  logic [6:0]  h0, h1, h2, h3;
  int checks = 0;
  int passed = 0;
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  always #5 clk = ~clk;
  displays_controller u_def (.clk(clk), .rst(rst), .num(num), .seg0(a0), .seg1(a1), .seg2(a2), .seg3(a3));
  displays_controller #(.BLANK_LEADING(1'b1)) u_blk (.clk(clk), .rst(rst), .num(num), .seg0(b0), .seg1(b1), .seg2(b2), .seg3(b3));
  displays_controller #(.SEG_ACTIVE_LOW(1'b0)) u_ah (.clk(clk), .rst(rst), .num(num), .seg0(h0), .seg1(h1), .seg2(h2), .seg3(h3));
  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step(input logic [15:0] v);
    @(negedge clk);
    num = v;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    num = 16'h1234;
    #1;
    chk("reset_no_clock", {a3, a2, a1, a0}, {4{7'h7F}});
    chk("reset_ah_no_clock", {h3, h2, h1, h0}, 28'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", {a3, a2, a1, a0}, {4{7'h7F}});
    @(negedge clk);
    rst = 1'b0;
    num = 16'h0000;
    #1;
    chk("pre_edge_blank", {a3, a2, a1, a0}, {4{7'h7F}});
    @(posedge clk);
    #1;
    chk("zero", {a3, a2, a1, a0}, {4{7'h40}});
    step(16'h1234);
    chk("1234", {a3, a2, a1, a0}, {7'h79, 7'h24, 7'h30, 7'h19});
    step(16'hABCD);
    chk("ABCD", {a3, a2, a1, a0}, {7'h08, 7'h03, 7'h46, 7'h21});
    @(negedge clk);
    num = 16'h5555;
    #2;
    chk("between_edges", {a3, a2, a1, a0}, {7'h08, 7'h03, 7'h46, 7'h21});
    for (int v = 0; v < 16; v++) begin
      step({4{v[3:0]}});
      chk("sweep_al", {a3, a2, a1, a0}, {4{~tbl[v]}});
      chk("sweep_ah", {h3, h2, h1, h0}, {4{tbl[v]}});
    end
    step(16'h0045);
    chk("blank_0045", {b3, b2, b1, b0}, {7'h7F, 7'h7F, 7'h19, 7'h12});
    chk("noblank_0045", {a3, a2, a1, a0}, {7'h40, 7'h40, 7'h19, 7'h12});
    step(16'h0000);
    chk("blank_0000", {b3, b2, b1, b0}, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    step(16'h0102);
    chk("blank_0102", {b3, b2, b1, b0}, {7'h7F, 7'h79, 7'h40, 7'h24});
    step(16'h000A);
    chk("blank_000A", {b3, b2, b1, b0}, {7'h7F, 7'h7F, 7'h7F, 7'h08});
    step(16'h1000);
    chk("blank_1000", {b3, b2, b1, b0}, {7'h79, 7'h40, 7'h40, 7'h40});
    step(16'h0009);
    chk("ah_0009", {h3, h2, h1, h0}, {7'h3F, 7'h3F, 7'h3F, 7'h6F});
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ah_async_reset", {h3, h2, h1, h0}, 28'h0);
    chk("al_async_reset", {a3, a2, a1, a0}, {4{7'h7F}});
    chk("blk_async_reset", {b3, b2, b1, b0}, {4{7'h7F}});
    @(negedge clk);
    rst = 1'b0;
    num = 16'hF00D;
    @(posedge clk);
    #1;
    chk("post_reset_load", {a3, a2, a1, a0}, {7'h0E, 7'h40, 7'h40, 7'h21});
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
